// File: rtl/mem_stage_if.sv
// Data-memory request/grant/response bus between mem_stage and memory.
// master: req, we, addr, wdata, wstrb out; gnt, rvalid, rdata in.
interface mem_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, wstrb,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, wstrb,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_stage.sv
// RV32 memory-access stage: issues loads/stores, aligns load data,
// registers write-back. Ports: execute bundle in, stall out, dmem bus, wb_*.
module mem_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [31:0] alu_result,
    input  logic [31:0] rs2_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd_in,
    input  logic        reg_write_in,
    output logic        stall,
    mem_stage_if.master dmem,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic [31:0] wb_data,
    output logic        mem_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic        we_q, rw_q;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q;

    logic        memop, bad, mis, ill;
    logic [1:0]  off;
    logic [31:0] st_wdata;
    logic [3:0]  st_strb;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;
    logic        to_hit;
    logic        done_op, done_to;

    assign memop  = valid_in & (mem_read | mem_write);
    assign off    = alu_result[1:0];
    assign to_hit = (cnt_q == TO_LAST);

    // Size comes from funct3[1:0]; bit 2 is the unsigned flag (loads only).
    always_comb begin
        mis = 1'b0;
        unique case (funct3[1:0])
            2'b01:   mis = off[0];
            2'b10:   mis = |off;
            default: mis = 1'b0;
        endcase
        ill = (funct3[1:0] == 2'b11)
            | (funct3[2] & (mem_write | funct3[1]));
        bad = mis | ill;
    end

    always_comb begin
        st_wdata = rs2_data;
        st_strb  = 4'b1111;
        unique case (funct3[1:0])
            2'b00: begin
                st_wdata = {4{rs2_data[7:0]}};
                st_strb  = 4'b0001 << off;
            end
            2'b01: begin
                st_wdata = {2{rs2_data[15:0]}};
                st_strb  = 4'b0011 << off;
            end
            default: begin
                st_wdata = rs2_data;
                st_strb  = 4'b1111;
            end
        endcase
    end

    always_comb begin
        ld_byte = dmem.rdata[7:0];
        unique case (addr_q[1:0])
            2'd0: ld_byte = dmem.rdata[7:0];
            2'd1: ld_byte = dmem.rdata[15:8];
            2'd2: ld_byte = dmem.rdata[23:16];
            2'd3: ld_byte = dmem.rdata[31:24];
            default: ld_byte = dmem.rdata[7:0];
        endcase
        ld_half = addr_q[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
        unique case (f3_q)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_val = {24'd0, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_val = {16'd0, ld_half};
            default: ld_val = dmem.rdata;
        endcase
    end

    assign dmem.we    = (state_q == REQ) & we_q;
    assign dmem.addr  = {addr_q[31:2], 2'b00};
    assign dmem.wdata = wdata_q;
    assign dmem.wstrb = wstrb_q;

    // Grant/rvalid take priority over a timeout landing in the same cycle.
    always_comb begin
        state_d  = state_q;
        stall    = 1'b0;
        dmem.req = 1'b0;
        done_op  = 1'b0;
        done_to  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (memop & ~bad) begin
                    state_d = REQ;
                    stall   = 1'b1;
                end
            end
            REQ: begin
                dmem.req = 1'b1;
                if (dmem.gnt) begin
                    if (we_q) begin
                        state_d = IDLE;
                        done_op = 1'b1;
                    end else begin
                        state_d = WAIT;
                        stall   = 1'b1;
                    end
                end else if (to_hit) begin
                    state_d = IDLE;
                    done_to = 1'b1;
                end else begin
                    stall = 1'b1;
                end
            end
            WAIT: begin
                if (dmem.rvalid) begin
                    state_d = IDLE;
                    done_op = 1'b1;
                end else if (to_hit) begin
                    state_d = IDLE;
                    done_to = 1'b1;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q && state_d != IDLE)
                cnt_q <= 8'd0;
            else if (state_q != IDLE)
                cnt_q <= cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            wstrb_q      <= 4'd0;
            we_q         <= 1'b0;
            rw_q         <= 1'b0;
            f3_q         <= 3'd0;
            rd_q         <= 5'd0;
            wb_valid     <= 1'b0;
            wb_rd        <= 5'd0;
            wb_reg_write <= 1'b0;
            wb_data      <= 32'd0;
            mem_err      <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            mem_err  <= 1'b0;
            if (state_q == IDLE && valid_in) begin
                if (!memop || bad) begin
                    wb_valid     <= 1'b1;
                    mem_err      <= memop;
                    wb_rd        <= rd_in;
                    wb_reg_write <= ~memop & reg_write_in;
                    wb_data      <= alu_result;
                end else begin
                    addr_q  <= alu_result;
                    wdata_q <= st_wdata;
                    wstrb_q <= mem_write ? st_strb : 4'd0;
                    we_q    <= mem_write;
                    rw_q    <= reg_write_in;
                    f3_q    <= funct3;
                    rd_q    <= rd_in;
                end
            end
            if (done_op) begin
                wb_valid     <= 1'b1;
                wb_rd        <= rd_q;
                wb_reg_write <= ~we_q & rw_q;
                if (!we_q)
                    wb_data <= ld_val;
            end
            if (done_to) begin
                wb_valid     <= 1'b1;
                mem_err      <= 1'b1;
                wb_rd        <= rd_q;
                wb_reg_write <= 1'b0;
            end
        end
    end

endmodule
